// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical
// counters, and a one-pixel-delayed sync/colour pipeline so that hsync,
// vsync and blanked rgb leave the block mutually aligned with the renderer's
// one-clock registered colour.
module vga_timing #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rgb_in,
  output logic [9:0] xaddr,
  output logic [9:0] yaddr,
  output logic       pix_en,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [2:0] vga_rgb,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             pix_next;
  logic             x_end;
  logic             y_end;
  logic             active;
  logic             hs_zone;
  logic             vs_zone;

  // Divider successor and decodes of the pixel currently being displayed
  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
    pix_next = (div_next == DIV_LAST);
    x_end    = (xaddr == H_LAST);
    y_end    = (yaddr == V_LAST);
    active   = (xaddr < H_ACT) && (yaddr < V_ACT);
    hs_zone  = (xaddr >= HS_START) && (xaddr < HS_END);
    vs_zone  = (yaddr >= VS_START) && (yaddr < VS_END);
  end

  // Divider, raster counters and the one-pixel-delayed output pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      pix_en     <= 1'b0;
      frame_tick <= 1'b0;
      xaddr      <= '0;
      yaddr      <= '0;
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      vga_rgb    <= '0;
    end else begin
      div    <= div_next;
      // pix_en and frame_tick are registered from div_next so they are high
      // exactly while div==CLK_DIV-1; counters are frozen in that cycle, so
      // frame_tick sees the same (last,last) position the wrap will consume.
      pix_en     <= pix_next;
      frame_tick <= pix_next && x_end && y_end;
      if (pix_en) begin
        if (x_end) begin
          xaddr <= '0;
          yaddr <= y_end ? '0 : yaddr + 1'b1;
        end else begin
          xaddr <= xaddr + 1'b1;
        end
        vga_rgb <= active ? rgb_in : '0;
        vga_hs  <= !hs_zone;
        vga_vs  <= !vs_zone;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing using a reduced raster geometry so that
// several whole frames fit in a short run. Two instances (CLK_DIV=2 and 4)
// share clock, reset and rgb_in; expectations come from a closed-form model
// driven only by the number of clock edges since reset release.
module tb_vga_timing;

  localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int unsigned VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HA + HF + HS + HB;   // 25
  localparam int unsigned VT = VA + VF + VS + VB;   // 15
  localparam int unsigned FRAME_PIX = HT * VT;      // 375

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rgb_in = 3'b000;

  logic [9:0] x2, y2, x4, y4;
  logic       pe2, hs2, vs2, ft2, pe4, hs4, vs4, ft4;
  logic [2:0] rgb2, rgb4;

  vga_timing #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .xaddr(x2), .yaddr(y2),
    .pix_en(pe2), .vga_hs(hs2), .vga_vs(vs2), .vga_rgb(rgb2), .frame_tick(ft2)
  );

  vga_timing #(
    .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .xaddr(x4), .yaddr(y4),
    .pix_en(pe4), .vga_hs(hs4), .vga_vs(vs4), .vga_rgb(rgb4), .frame_tick(ft4)
  );

  always #5 clk = ~clk;

  // Edge count since reset release, and the rgb_in value seen at the most
  // recent pixel boundary of each divider setting.
  int unsigned k;
  logic [2:0]  lr2, lr4;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k   <= 0;
      lr2 <= 3'b000;
      lr4 <= 3'b000;
    end else begin
      if (k % 2 == 1) lr2 <= rgb_in;
      if (k % 4 == 3) lr4 <= rgb_in;
      k <= k + 1;
    end
  end

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pe;
    logic       hs;
    logic       vs;
    logic       ft;
    logic [2:0] rgb;
  } exp_t;

  // Expected outputs after kk edges: pixel n=kk/d is on screen; outputs
  // describe pixel n-1 (the one that just ended), or reset values if none.
  function automatic exp_t model(int unsigned kk, int unsigned d, logic [2:0] lr);
    int unsigned n, m, xe, ye;
    exp_t e;
    n    = kk / d;
    e.pe = (kk % d == d - 1);
    e.x  = 10'(n % HT);
    e.y  = 10'((n / HT) % VT);
    e.ft = e.pe && (n % FRAME_PIX == FRAME_PIX - 1);
    if (n == 0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.rgb = 3'b000;
    end else begin
      m     = n - 1;
      xe    = m % HT;
      ye    = (m / HT) % VT;
      e.hs  = !(xe >= HA + HF && xe < HA + HF + HS);
      e.vs  = !(ye >= VA + VF && ye < VA + VF + VS);
      e.rgb = (xe < HA && ye < VA) ? lr : 3'b000;
    end
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      compared++;
      if ({x2, y2, pe2, hs2, vs2, rgb2, ft2} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0}) begin
        mismatched++;
        $display("FAIL reset_d2 got x=%0d y=%0d pe=%b hs=%b vs=%b rgb=%b ft=%b want 0 0 0 1 1 000 0",
                 x2, y2, pe2, hs2, vs2, rgb2, ft2);
      end
      compared++;
      if ({x4, y4, pe4, hs4, vs4, rgb4, ft4} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0}) begin
        mismatched++;
        $display("FAIL reset_d4 got x=%0d y=%0d pe=%b hs=%b vs=%b rgb=%b ft=%b want 0 0 0 1 1 000 0",
                 x4, y4, pe4, hs4, vs4, rgb4, ft4);
      end
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      e = model(k, 2, lr2);
      compared++;
      if ({pe2, x2, hs2, vs2, rgb2} !== {e.pe, e.x, e.hs, e.vs, e.rgb}) begin
        mismatched++;
        $display("FAIL release_d2 k=%0d got pe=%b x=%0d hs=%b vs=%b rgb=%b want pe=%b x=%0d hs=%b vs=%b rgb=%b",
                 k, pe2, x2, hs2, vs2, rgb2, e.pe, e.x, e.hs, e.vs, e.rgb);
      end
    end
  endtask

  task automatic test_line();
    exp_t e;
    int unsigned low = 0;
    int unsigned budget = 0;
    while (k < 4 * HT && budget < 1000) begin
      @(negedge clk);
      budget++;
      e = model(k, 2, lr2);
      compared++;
      if ({x2, y2, hs2} !== {e.x, e.y, e.hs}) begin
        mismatched++;
        $display("FAIL line_d2 k=%0d got x=%0d y=%0d hs=%b want x=%0d y=%0d hs=%b",
                 k, x2, y2, hs2, e.x, e.y, e.hs);
      end
      if (k >= 2 * HT && !hs2) low++;
      rgb_in = 3'($urandom_range(7));
    end
    compared++;
    if (k != 4 * HT || low != HS * 2) begin
      mismatched++;
      $display("FAIL hs_width got %0d clks low (k=%0d) want %0d", low, k, HS * 2);
    end
  endtask

  task automatic test_frame();
    exp_t e;
    int unsigned vlow = 0;
    int unsigned ticks = 0;
    int unsigned last_tick = 0;
    int unsigned budget = 0;
    while (k < 1600 && budget < 3000) begin
      @(negedge clk);
      budget++;
      e = model(k, 2, lr2);
      compared++;
      if ({y2, vs2, ft2, rgb2} !== {e.y, e.vs, e.ft, e.rgb}) begin
        mismatched++;
        $display("FAIL frame_d2 k=%0d got y=%0d vs=%b ft=%b rgb=%b want y=%0d vs=%b ft=%b rgb=%b",
                 k, y2, vs2, ft2, rgb2, e.y, e.vs, e.ft, e.rgb);
      end
      if (k >= 2 * FRAME_PIX && k < 4 * FRAME_PIX && !vs2) vlow++;
      if (ft2) begin
        if (ticks > 0) begin
          compared++;
          if (k - last_tick != 2 * FRAME_PIX) begin
            mismatched++;
            $display("FAIL tick_period_d2 got %0d clks want %0d", k - last_tick, 2 * FRAME_PIX);
          end
        end
        last_tick = k;
        ticks++;
      end
      rgb_in = 3'($urandom_range(7));
    end
    compared++;
    if (vlow != VS * HT * 2) begin
      mismatched++;
      $display("FAIL vs_width got %0d clks low want %0d", vlow, VS * HT * 2);
    end
    compared++;
    if (ticks != 2) begin
      mismatched++;
      $display("FAIL tick_count_d2 got %0d want 2", ticks);
    end
  endtask

  task automatic test_rgb();
    exp_t e;
    int unsigned on = 0;
    int unsigned start = k;
    rgb_in = 3'b111;
    repeat (2 * FRAME_PIX) begin
      @(negedge clk);
      e = model(k, 2, lr2);
      compared++;
      if (rgb2 !== e.rgb) begin
        mismatched++;
        $display("FAIL rgb_hold k=%0d x=%0d y=%0d got %b want %b", k, x2, y2, rgb2, e.rgb);
      end
      if (rgb2 === 3'b111) on++;
    end
    // One full frame of clocks: exactly HA*VA pixels lit, CLK_DIV clks each.
    compared++;
    if (on != HA * VA * 2) begin
      mismatched++;
      $display("FAIL rgb_lit_count from k=%0d got %0d want %0d", start, on, HA * VA * 2);
    end
  endtask

  task automatic test_midframe_reset();
    exp_t e;
    int unsigned budget = 0;
    while (!(k % 2 == 0 && (k / 2) % FRAME_PIX == 5 * HT + 10) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    compared++;
    if (budget >= 2000) begin
      mismatched++;
      $display("FAIL midreset_reach timed out k=%0d", k);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({x2, y2, pe2, hs2, vs2, rgb2, ft2, x4, y4, pe4, hs4, vs4, rgb4, ft4} !==
        {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0}) begin
      mismatched++;
      $display("FAIL async_reset got x2=%0d y2=%0d hs2=%b vs2=%b rgb2=%b x4=%0d y4=%0d want zeros, syncs high",
               x2, y2, hs2, vs2, rgb2, x4, y4);
    end
    repeat (3) begin
      @(negedge clk);
      compared++;
      if ({x2, y2, ft2, ft4, pe2, pe4} !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL reset_hold got x=%0d y=%0d ft2=%b ft4=%b pe2=%b pe4=%b want all 0",
                 x2, y2, ft2, ft4, pe2, pe4);
      end
    end
    rst_n = 1'b1;
    repeat (4 * HT) begin
      @(negedge clk);
      e = model(k, 2, lr2);
      compared++;
      if ({x2, y2, pe2, hs2, vs2, ft2, rgb2} !== {e.x, e.y, e.pe, e.hs, e.vs, e.ft, e.rgb}) begin
        mismatched++;
        $display("FAIL restart_d2 k=%0d got x=%0d y=%0d pe=%b hs=%b vs=%b ft=%b rgb=%b want x=%0d y=%0d pe=%b hs=%b vs=%b ft=%b rgb=%b",
                 k, x2, y2, pe2, hs2, vs2, ft2, rgb2, e.x, e.y, e.pe, e.hs, e.vs, e.ft, e.rgb);
      end
      rgb_in = 3'($urandom_range(7));
    end
  endtask

  task automatic test_div4();
    exp_t e;
    int unsigned ticks = 0;
    int unsigned last_tick = 0;
    int unsigned budget = 0;
    while (k < 3200 && budget < 4000) begin
      @(negedge clk);
      budget++;
      e = model(k, 4, lr4);
      compared++;
      if ({x4, y4, pe4, hs4, vs4, ft4, rgb4} !== {e.x, e.y, e.pe, e.hs, e.vs, e.ft, e.rgb}) begin
        mismatched++;
        $display("FAIL div4 k=%0d got x=%0d y=%0d pe=%b hs=%b vs=%b ft=%b rgb=%b want x=%0d y=%0d pe=%b hs=%b vs=%b ft=%b rgb=%b",
                 k, x4, y4, pe4, hs4, vs4, ft4, rgb4, e.x, e.y, e.pe, e.hs, e.vs, e.ft, e.rgb);
      end
      if (ft4) begin
        if (ticks > 0) begin
          compared++;
          if (k - last_tick != 4 * FRAME_PIX) begin
            mismatched++;
            $display("FAIL tick_period_d4 got %0d clks want %0d", k - last_tick, 4 * FRAME_PIX);
          end
        end
        last_tick = k;
        ticks++;
      end
      rgb_in = 3'($urandom_range(7));
    end
    compared++;
    if (ticks != 2) begin
      mismatched++;
      $display("FAIL tick_count_d4 got %0d want 2", ticks);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_rgb();
    test_midframe_reset();
    test_div4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
